nrisc_ctrl_fsm: RTL

- Multicycle control unit for the 8-bit nRisc core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the registered ALU's `op` and `controle` inputs, plus the register-file, PC, IR and memory strobes.
- Consumes the ALU's combinational `Zero` flag for branches and keeps a retired-instruction counter.

---
 rtl/nrisc_pkg.sv | 34 +++
 rtl/nrisc_retire_cnt.sv | 19 +
 rtl/nrisc_ctrl_fsm.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// nRisc control-unit shared definitions: opcodes, ALU encodings,
// instruction field positions and the control FSM state type.
package nrisc_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SHIFT = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_HALT  = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SHIFT = 3'b001;
  localparam logic [2:0] ALU_NOP   = 3'b111;

  localparam int OP_HI    = 7;
  localparam int OP_LO    = 5;
  localparam int FLAG_BIT = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_HALTED,
    S_FAULT
  } state_t;

endpackage

// File: rtl/nrisc_retire_cnt.sv
// Retired-instruction counter: synchronous clear, increment enable,
// wraps silently at 2^W.
module nrisc_retire_cnt #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clock) begin
    if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/nrisc_ctrl_fsm.sv
// Multicycle control FSM for the 8-bit nRisc core.
// Optional memory-wait timeout: define NRISC_MEM_TIMEOUT_EN.
module nrisc_ctrl_fsm
  import nrisc_pkg::*;
#(
  parameter int RETIRE_W       = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [7:0]          instr,
  input  logic                mem_ready,
  input  logic                Zero,
  output logic [2:0]          alu_op,
  output logic                alu_ctrl,
  output logic                ir_we,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                reg_we,
  output logic                reg_wsel,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                halted,
  output logic                fault,
  output logic [RETIRE_W-1:0] retired
);

  state_t     state;
  logic [2:0] op;
  logic       flag;
  logic       timeout;
  logic       ret_inc;
  logic [3:0] unused_bits;

  assign unused_bits = instr[4:1];

`ifdef NRISC_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wcnt;
  logic              waiting;

  assign waiting = (state == S_FETCH || state == S_MEM)
                   && !mem_ready;

  // Cleared whenever not stalled, so every FETCH/MEM entry starts at 0.
  always_ff @(posedge clock) begin
    if (reset || !waiting)
      wcnt <= '0;
    else
      wcnt <= wcnt + WAIT_W'(1);
  end

  assign timeout = waiting
    && (wcnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      op    <= '0;
      flag  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:
          if (run) state <= S_FETCH;
        S_FETCH:
          if (mem_ready) begin
            op    <= instr[OP_HI:OP_LO];
            flag  <= instr[FLAG_BIT];
            state <= S_DECODE;
          end else if (timeout) begin
            state <= S_FAULT;
          end
        S_DECODE:
          unique case (op)
            OP_ADD, OP_SHIFT,
            OP_LOAD, OP_STORE: state <= S_EXEC;
            OP_BEQ:            state <= S_BRANCH;
            OP_JMP:            state <= S_FETCH;
            OP_HALT:           state <= S_HALTED;
            default:           state <= S_FAULT;
          endcase
        S_EXEC:
          if (op == OP_LOAD || op == OP_STORE)
            state <= S_MEM;
          else
            state <= S_WB;
        S_MEM:
          if (mem_ready)
            state <= (op == OP_LOAD) ? S_WB : S_FETCH;
          else if (timeout)
            state <= S_FAULT;
        S_WB:     state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_HALTED: state <= S_HALTED;
        S_FAULT:  state <= S_FAULT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_op   = ALU_NOP;
    alu_ctrl = 1'b0;
    ir_we    = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    reg_we   = 1'b0;
    reg_wsel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    ret_inc  = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_we  = mem_ready;
        pc_inc = mem_ready;
      end
      S_DECODE: begin
        pc_load = (op == OP_JMP);
        ret_inc = (op == OP_JMP) || (op == OP_HALT);
      end
      S_EXEC: begin
        alu_op   = (op == OP_SHIFT) ? ALU_SHIFT : ALU_ADD;
        alu_ctrl = (op == OP_SHIFT) && flag;
      end
      S_MEM: begin
        mem_rd  = (op == OP_LOAD);
        mem_wr  = (op == OP_STORE);
        ret_inc = mem_ready && (op == OP_STORE);
      end
      S_WB: begin
        reg_we   = 1'b1;
        reg_wsel = (op == OP_LOAD);
        ret_inc  = 1'b1;
      end
      S_BRANCH: begin
        alu_op  = ALU_ADD;
        pc_load = Zero;
        ret_inc = 1'b1;
      end
      S_HALTED: halted = 1'b1;
      S_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: ;
    endcase
  end

  nrisc_retire_cnt #(
    .W (RETIRE_W)
  ) u_retire (
    .clock (clock),
    .clr   (reset),
    .inc   (ret_inc),
    .cnt   (retired)
  );

endmodule
